// File: rtl/usb_auth_responder.sv
// USB Type-C attach detector and authentication responder.
// Debounces the CC attach pattern, asks the host for an authentication
// request, builds the matching response header and waits for the host ack.
module usb_auth_responder #(
  parameter int unsigned MSG_LEN  = 2080,
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned TIMEOUT  = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               CC1,
  input  logic               CC2,
  input  logic               resp_req_in,
  input  logic [MSG_LEN-1:0] auth_msg_resp_in,
  input  logic               Ack_out_resp,
  output logic               resp_req_out,
  output logic [MSG_LEN-1:0] auth_msg_resp_out,
  output logic               resp_valid,
  output logic               attached,
  output logic               flip,
  output logic               auth_err
);

  localparam int unsigned HDR_W = 64;
  localparam int unsigned PAY_W = MSG_LEN - HDR_W;
  localparam int unsigned CAP_W = 56;
  localparam int unsigned DB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int unsigned WT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_REQ,
    ST_WAIT_MSG,
    ST_BUILD,
    ST_WAIT_ACK,
    ST_ERROR
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         pat_q, pat_d;
  logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
  logic [WT_W-1:0]    wait_cnt_q, wait_cnt_d;
  // Captured header without param2: {version, type, param1, offset, length}
  logic [CAP_W-1:0]   hdr_q, hdr_d;
  logic [MSG_LEN-1:0] resp_q, resp_d;
  logic               resp_req_q, resp_req_d;
  logic               resp_valid_q, resp_valid_d;
  logic               attached_q, attached_d;
  logic               flip_q, flip_d;
  logic               auth_err_q, auth_err_d;

  logic [1:0]         cc_pat;
  logic               detach;
  logic [HDR_W-1:0]   resp_hdr_c;
  logic [7:0]         req_ver, req_type, req_p1;
  logic [31:0]        req_off_len;
  logic               unused_msg_bits;

  assign cc_pat = {CC1, CC2};
  assign detach = attached_q && (CC1 == CC2);

  // param2 and the request payload never influence the response
  assign unused_msg_bits = ^{auth_msg_resp_in[MSG_LEN-25 -: 8], auth_msg_resp_in[PAY_W-1:0]};

  assign req_ver     = hdr_q[55:48];
  assign req_type    = hdr_q[47:40];
  assign req_p1      = hdr_q[39:32];
  assign req_off_len = hdr_q[31:0];

  // Response header: echo for known types, error codes otherwise
  always_comb begin
    resp_hdr_c = {8'h01, 8'h7F, 8'h01, 8'h00, 32'h0};
    if (req_ver != 8'h01) begin
      resp_hdr_c = {8'h01, 8'h7F, 8'h02, 8'h00, 32'h0};
    end else if (req_type == 8'h81 || req_type == 8'h82 || req_type == 8'h83) begin
      resp_hdr_c = {8'h01, req_type & 8'h7F, req_p1, 8'h00, req_off_len};
    end
  end

  // Next-state and registered-output logic; detach overrides every state
  always_comb begin
    state_d      = state_q;
    pat_d        = pat_q;
    db_cnt_d     = db_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    hdr_d        = hdr_q;
    resp_d       = resp_q;
    resp_req_d   = 1'b0;
    resp_valid_d = resp_valid_q;
    attached_d   = attached_q;
    flip_d       = flip_q;
    auth_err_d   = auth_err_q;

    if (detach) begin
      state_d      = ST_IDLE;
      db_cnt_d     = '0;
      wait_cnt_d   = '0;
      resp_valid_d = 1'b0;
      attached_d   = 1'b0;
      flip_d       = 1'b0;
      auth_err_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (CC1 != CC2) begin
            pat_d    = cc_pat;
            db_cnt_d = '0;
            state_d  = ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (cc_pat != pat_q) begin
            db_cnt_d = '0;
            state_d  = ST_IDLE;
          end else if (db_cnt_q >= DB_W'(DEBOUNCE - 1)) begin
            db_cnt_d   = '0;
            attached_d = 1'b1;
            flip_d     = CC2;
            resp_req_d = 1'b1;
            state_d    = ST_REQ;
          end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
          end
        end
        ST_REQ: begin
          wait_cnt_d = '0;
          state_d    = ST_WAIT_MSG;
        end
        ST_WAIT_MSG: begin
          if (!resp_req_in) begin
            hdr_d   = {auth_msg_resp_in[MSG_LEN-1 -: 24], auth_msg_resp_in[MSG_LEN-33 -: 32]};
            state_d = ST_BUILD;
          end else if (wait_cnt_q >= WT_W'(TIMEOUT - 1)) begin
            auth_err_d   = 1'b1;
            resp_valid_d = 1'b0;
            state_d      = ST_ERROR;
          end else begin
            wait_cnt_d = wait_cnt_q + WT_W'(1);
          end
        end
        ST_BUILD: begin
          resp_d       = {resp_hdr_c, {PAY_W{1'b0}}};
          resp_valid_d = 1'b1;
          wait_cnt_d   = '0;
          state_d      = ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (Ack_out_resp) begin
            resp_valid_d = 1'b0;
            resp_req_d   = 1'b1;
            state_d      = ST_REQ;
          end else if (wait_cnt_q >= WT_W'(TIMEOUT - 1)) begin
            auth_err_d   = 1'b1;
            resp_valid_d = 1'b0;
            state_d      = ST_ERROR;
          end else begin
            wait_cnt_d = wait_cnt_q + WT_W'(1);
          end
        end
        ST_ERROR: begin
          state_d = ST_ERROR;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers, cleared asynchronously by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      pat_q        <= '0;
      db_cnt_q     <= '0;
      wait_cnt_q   <= '0;
      hdr_q        <= '0;
      resp_q       <= '0;
      resp_req_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      attached_q   <= 1'b0;
      flip_q       <= 1'b0;
      auth_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pat_q        <= pat_d;
      db_cnt_q     <= db_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      hdr_q        <= hdr_d;
      resp_q       <= resp_d;
      resp_req_q   <= resp_req_d;
      resp_valid_q <= resp_valid_d;
      attached_q   <= attached_d;
      flip_q       <= flip_d;
      auth_err_q   <= auth_err_d;
    end
  end

  assign resp_req_out      = resp_req_q;
  assign auth_msg_resp_out = resp_q;
  assign resp_valid        = resp_valid_q;
  assign attached          = attached_q;
  assign flip              = flip_q;
  assign auth_err          = auth_err_q;

endmodule
